// File: rtl/seven_segment_pkg.sv
// Shared constants and helpers for the stopwatch seven-segment display path.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package seven_segment_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Clock cycles spent on each digit before the scan advances.
    function automatic int calc_divide(input int board_hz, input int scan_hz);
        return board_hz / scan_hz;
    endfunction

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bcd_to_seven_segment.sv
// Combinational BCD to active-low seven-segment decoder.
// Non-decimal codes show a dash so corrupted digits are visible on the display.
module bcd_to_seven_segment
    import seven_segment_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        case (value)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed driver for the four-digit common-anode stopwatch display.
// Scans one digit per prescaler period with an all-anodes-off guard after each change.
module seven_segment_scanner
    import seven_segment_pkg::*;
#(
    parameter int NUMBER_OF_DIGITS            = 4,
    parameter int NUMBER_OF_BITS_PER_DIGIT    = 4,
    parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int SCAN_FREQUENCY_IN_HZ        = 1000,
    parameter int GUARD_CYCLES                = 4,
    parameter int LEADING_ZERO_BLANKING       = 0
)
(
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] number,
    input  logic [NUMBER_OF_DIGITS-1:0]                          digit_mask,
    input  logic [NUMBER_OF_DIGITS-1:0]                          dp_mask,
    output logic [NUMBER_OF_DIGITS-1:0]                          an,
    output logic [6:0]                                           seg,
    output logic                                                 dp
);

    localparam int DIVIDE  = calc_divide(BOARD_CLOCK_FREQUENCY_IN_HZ, SCAN_FREQUENCY_IN_HZ);
    localparam int PRE_W   = clog2_min1(DIVIDE);
    localparam int IDX_W   = clog2_min1(NUMBER_OF_DIGITS);
    localparam int GUARD_W = clog2_min1(GUARD_CYCLES + 1);
    localparam int BITS    = NUMBER_OF_BITS_PER_DIGIT;

    localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(DIVIDE - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUMBER_OF_DIGITS - 1);
    localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYCLES);

    logic [PRE_W-1:0]            pre;
    logic [IDX_W-1:0]            idx;
    logic [GUARD_W-1:0]          guard;
    logic                        tick;

    logic [BITS-1:0]             digit;
    logic [NUMBER_OF_DIGITS-1:0] an_next;
    logic [NUMBER_OF_DIGITS-1:0] zero_from;
    logic                        zero_lead;
    logic                        visible;
    logic                        dp_sel;
    logic                        blank;
    logic [6:0]                  seg_dec;

    assign tick = (pre == PRE_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre   <= '0;
            idx   <= '0;
            guard <= GUARD_LOAD;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            // A reload on tick overrides the decrement reaching zero.
            if (tick) begin
                guard <= GUARD_LOAD;
            end else if (guard != '0) begin
                guard <= guard - 1'b1;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        logic run;
        digit     = '0;
        an_next   = '1;
        zero_from = '0;
        zero_lead = 1'b0;
        visible   = 1'b0;
        dp_sel    = 1'b0;
        run       = 1'b1;
        // zero_from[i]: digits i..N-1 are all zero.
        for (int i = NUMBER_OF_DIGITS - 1; i >= 0; i--) begin
            run          = run && (number[i*BITS +: BITS] == '0);
            zero_from[i] = run;
        end
        for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                digit      = number[i*BITS +: BITS];
                an_next[i] = 1'b0;
                zero_lead  = zero_from[i];
                visible    = digit_mask[i];
                dp_sel     = dp_mask[i];
            end
        end
        blank = !visible || ((LEADING_ZERO_BLANKING != 0) && (idx != '0) && zero_lead);
    end

    bcd_to_seven_segment u_decode (
        .value (4'(digit)),
        .seg   (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (rst || guard != '0 || blank) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_dec;
            dp  <= ~dp_sel;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench for seven_segment_scanner: stimulus queues expected outputs
// tagged with a cycle number, a monitor pops and compares them at that cycle.
module tb_seven_segment_scanner;

    logic        clk;
    logic        rst;
    logic [15:0] number;
    logic [3:0]  digit_mask;
    logic [3:0]  dp_mask;
    logic [3:0]  an_a, an_b;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;

    seven_segment_scanner #(
        .NUMBER_OF_DIGITS(4), .NUMBER_OF_BITS_PER_DIGIT(4),
        .BOARD_CLOCK_FREQUENCY_IN_HZ(100), .SCAN_FREQUENCY_IN_HZ(10),
        .GUARD_CYCLES(4), .LEADING_ZERO_BLANKING(0)
    ) dut_a (
        .clk(clk), .rst(rst), .number(number), .digit_mask(digit_mask),
        .dp_mask(dp_mask), .an(an_a), .seg(seg_a), .dp(dp_a)
    );

    seven_segment_scanner #(
        .NUMBER_OF_DIGITS(4), .NUMBER_OF_BITS_PER_DIGIT(4),
        .BOARD_CLOCK_FREQUENCY_IN_HZ(100), .SCAN_FREQUENCY_IN_HZ(10),
        .GUARD_CYCLES(4), .LEADING_ZERO_BLANKING(1)
    ) dut_b (
        .clk(clk), .rst(rst), .number(number), .digit_mask(digit_mask),
        .dp_mask(dp_mask), .an(an_b), .seg(seg_b), .dp(dp_b)
    );

    typedef struct {
        int         at;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        bit         lz;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   base  = 0;
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s @cyc %0d: got {an,seg,dp}=%h want %h", name, cyc, got, want);
        end
    endtask

    // Queue an expectation for relative cycle k (cycle 1 = first edge with rst low).
    task automatic push(input int k, input logic [3:0] an_e, input logic [6:0] seg_e,
                        input logic dp_e, input bit lz, input string name);
        exp_t e;
        int   pos;
        e.at = base + k; e.an = an_e; e.seg = seg_e; e.dp = dp_e; e.lz = lz; e.name = name;
        pos = q.size();
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].at > e.at) begin
                pos = i;
                break;
            end
        end
        q.insert(pos, e);
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        while (q.size() > 0 && q[0].at <= cyc) begin
            mon_e = q.pop_front();
            if (mon_e.lz)
                check(mon_e.name, {an_b, seg_b, dp_b}, {mon_e.an, mon_e.seg, mon_e.dp});
            else
                check(mon_e.name, {an_a, seg_a, dp_a}, {mon_e.an, mon_e.seg, mon_e.dp});
        end
    end

    // Called at a negedge; rst is seen on the next edge, released after hold edges.
    task automatic do_reset(input int hold);
        rst  = 1'b1;
        base = cyc;
        push(1, 4'hF, 7'h7F, 1'b1, 0, "reset_edge");
        repeat (hold) @(negedge clk);
        rst  = 1'b0;
        base = cyc;
    endtask

    task automatic wait_to(input int k);
        while (cyc < base + k) @(negedge clk);
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        while (q.size() > 0) begin
            mon_e = q.pop_front();
            total++;
            bad++;
            $display("FAIL %s: expectation at cyc %0d never compared (timeout)", mon_e.name, mon_e.at);
        end
    endtask

    initial begin
        rst = 1'b1; number = 16'h1259; digit_mask = 4'hF; dp_mask = 4'h0;
        @(negedge clk);

        // Normal scan of 1259 plus reset-release guard window.
        do_reset(3);
        push(1,  4'hF, 7'h7F, 1'b1, 0, "s1_guard_c1");
        push(4,  4'hF, 7'h7F, 1'b1, 0, "s1_guard_c4");
        push(5,  4'hE, 7'h10, 1'b1, 0, "s1_d0_first");
        push(10, 4'hE, 7'h10, 1'b1, 0, "s1_d0_last");
        push(11, 4'hF, 7'h7F, 1'b1, 0, "s1_d1_guard_first");
        push(14, 4'hF, 7'h7F, 1'b1, 0, "s1_d1_guard_last");
        push(15, 4'hD, 7'h12, 1'b1, 0, "s1_d1_first");
        push(20, 4'hD, 7'h12, 1'b1, 0, "s1_d1_last");
        push(25, 4'hB, 7'h24, 1'b1, 0, "s1_d2");
        push(35, 4'h7, 7'h79, 1'b1, 0, "s1_d3_first");
        push(40, 4'h7, 7'h79, 1'b1, 0, "s1_d3_last");
        push(41, 4'hF, 7'h7F, 1'b1, 0, "s1_wrap_guard");
        push(45, 4'hE, 7'h10, 1'b1, 0, "s1_wrap_d0");
        push(35, 4'h7, 7'h79, 1'b1, 1, "s1_lzb_d3");
        drain();

        // Blink mask hides digit 2 for its whole slot.
        number = 16'h5959; digit_mask = 4'b1011;
        do_reset(1);
        push(5,  4'hE, 7'h10, 1'b1, 0, "s2_d0");
        push(15, 4'hD, 7'h12, 1'b1, 0, "s2_d1");
        push(21, 4'hF, 7'h7F, 1'b1, 0, "s2_d2_blank_first");
        push(25, 4'hF, 7'h7F, 1'b1, 0, "s2_d2_blank_mid");
        push(30, 4'hF, 7'h7F, 1'b1, 0, "s2_d2_blank_last");
        push(35, 4'h7, 7'h12, 1'b1, 0, "s2_d3");
        drain();

        // Leading-zero blanking.
        number = 16'h0005; digit_mask = 4'hF;
        do_reset(1);
        push(5,  4'hE, 7'h12, 1'b1, 1, "s3_lz_d0");
        push(15, 4'hF, 7'h7F, 1'b1, 1, "s3_lz_d1");
        push(25, 4'hF, 7'h7F, 1'b1, 1, "s3_lz_d2");
        push(35, 4'hF, 7'h7F, 1'b1, 1, "s3_lz_d3");
        push(15, 4'hD, 7'h40, 1'b1, 0, "s3_nolz_d1");
        push(35, 4'h7, 7'h40, 1'b1, 0, "s3_nolz_d3");
        drain();
        number = 16'h0000;
        do_reset(1);
        push(5,  4'hE, 7'h40, 1'b1, 1, "s3_zero_d0");
        push(15, 4'hF, 7'h7F, 1'b1, 1, "s3_zero_d1");
        drain();
        number = 16'h0500;
        do_reset(1);
        push(15, 4'hD, 7'h40, 1'b1, 1, "s3_inner_zero_d1");
        push(25, 4'hB, 7'h12, 1'b1, 1, "s3_inner_d2");
        push(35, 4'hF, 7'h7F, 1'b1, 1, "s3_lead_d3");
        drain();

        // Dash decode, decimal point, and mid-digit input change.
        number = 16'h12C4; dp_mask = 4'b0100;
        do_reset(1);
        push(5,  4'hE, 7'h19, 1'b1, 0, "s4_d0");
        push(15, 4'hD, 7'h3F, 1'b1, 0, "s4_dash_d1");
        push(21, 4'hF, 7'h7F, 1'b1, 0, "s4_dp_guard");
        push(25, 4'hB, 7'h24, 1'b0, 0, "s4_dp_on_first");
        push(30, 4'hB, 7'h24, 1'b0, 0, "s4_dp_on_last");
        push(35, 4'h7, 7'h79, 1'b1, 0, "s4_dp_off_d3");
        wait_to(6);
        number = 16'h12C0;
        push(7,  4'hE, 7'h40, 1'b1, 0, "s4_live_change");
        drain();

        // Reset pulsed inside the digit 2 slot.
        number = 16'h1259; dp_mask = 4'h0;
        do_reset(1);
        push(25, 4'hB, 7'h24, 1'b1, 0, "s5_before_pulse");
        wait_to(25);
        do_reset(1);
        push(1, 4'hF, 7'h7F, 1'b1, 0, "s5_after_c1");
        push(4, 4'hF, 7'h7F, 1'b1, 0, "s5_after_c4");
        push(5, 4'hE, 7'h10, 1'b1, 0, "s5_restart_d0");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
